// File: rtl/output_writeback.sv
// Result write-back: buffers (address, data) beats from the accumulation
// array in a small FIFO and drains them to an external memory write port
// under a request/grant handshake. Tracks layer progress and raises done
// once every beat of the output feature map has been written.
module output_writeback #(
    parameter int unsigned ACCUMULATION_WIDTH = 32,
    parameter int unsigned EXT_MEM_HEIGHT     = 1 << 20,
    parameter int unsigned EXT_MEM_WIDTH      = 32,  // must be >= ACCUMULATION_WIDTH
    parameter int unsigned FEATURE_MAP_WIDTH  = 64,
    parameter int unsigned FEATURE_MAP_HEIGHT = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 32,
    parameter int unsigned FIFO_DEPTH         = 8,   // power of 2, >= 2
    parameter int unsigned BASE_ADDR          = 0,
    localparam int unsigned ADDR_W = $clog2(EXT_MEM_HEIGHT),
    localparam int unsigned X_W    = $clog2(FEATURE_MAP_WIDTH),
    localparam int unsigned Y_W    = $clog2(FEATURE_MAP_HEIGHT),
    localparam int unsigned CH_W   = $clog2(OUTPUT_NB_CHANNELS)
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic                          in_valid,
    input  logic [X_W-1:0]                in_x,
    input  logic [Y_W-1:0]                in_y,
    input  logic [CH_W-1:0]               in_ch,
    output logic                          in_ready,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [EXT_MEM_WIDTH-1:0]      mem_wdata,
    input  logic                          mem_gnt,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          stray
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] TOTAL =
        32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                   state_q, state_d;
    logic [31:0]              beat_cnt_q, beat_cnt_d;
    logic                     overflow_q, overflow_d;
    logic                     stray_q, stray_d;

    // The entry presented on the write port stays in the FIFO until granted,
    // so occupancy includes the outstanding write.
    logic [ADDR_W-1:0]        fifo_addr_q [FIFO_DEPTH];
    logic [EXT_MEM_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_nxt;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [EXT_MEM_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                     fifo_full, fifo_empty;
    logic                     in_run, beat, push, drop, retire;
    logic [ADDR_W-1:0]        push_addr;
    logic [EXT_MEM_WIDTH-1:0] push_data;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_run     = (state_q == StRun);
    assign beat       = in_run && in_valid;
    assign retire     = mem_we_q && mem_gnt;
    // A retiring entry frees its slot in the same cycle.
    assign push       = beat && (!fifo_full || retire);
    assign drop       = beat && !push;
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    // Address math is done at 32 bits; truncation wraps modulo memory depth.
    assign push_addr = ADDR_W'(32'(BASE_ADDR) +
                       (32'(in_y) * 32'(FEATURE_MAP_WIDTH) + 32'(in_x)) *
                       32'(OUTPUT_NB_CHANNELS) + 32'(in_ch));
    assign push_data = EXT_MEM_WIDTH'(in_data);

    // Layer FSM, beat counter and sticky error flags.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        overflow_d = overflow_q;
        stray_d    = stray_q;
        if (in_valid && !in_run) begin
            stray_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    beat_cnt_d = '0;
                    overflow_d = 1'b0;
                    stray_d    = 1'b0;
                end
            end
            StRun: begin
                if (in_valid) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (drop) begin
                        overflow_d = 1'b1;
                    end
                    if (beat_cnt_d == TOTAL) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_empty && !mem_we_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = retire ? rd_ptr_nxt : rd_ptr_q;
        count_d  = count_q;
        if (push && !retire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && retire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Write port: present the head one cycle after it lands, hold it until
    // granted, then chain straight to the next stored entry if there is one.
    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (retire) begin
            if (count_q > CNT_W'(1)) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = fifo_addr_q[rd_ptr_nxt];
                mem_wdata_d = fifo_data_q[rd_ptr_nxt];
            end else begin
                mem_we_d = 1'b0;
            end
        end else if (!mem_we_q && !fifo_empty) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
        end
    end

    // Control state; reset discards queued entries and any pending write.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            stray_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            overflow_q  <= overflow_d;
            stray_q     <= stray_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // FIFO storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= push_addr;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

    assign in_ready  = !fifo_full;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign overflow  = overflow_q;
    assign stray     = stray_q;

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: a small-geometry instance exercised with
// directed corner sequences and randomized layers against a queue-based
// reference, plus two default-geometry instances checked from a vector table
// for address formation and wrap-around.
module tb_output_writeback;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned C    = 2;
    localparam int unsigned EMH  = 1024;
    localparam int unsigned BASE = 1000;
    localparam int unsigned TOT  = W * H * C;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [4:0]  ch;
        logic [31:0] data;
        logic [19:0] exp_d;
        logic [19:0] exp_w;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    wr_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    // small instance
    logic        start = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_x = '0;
    logic [1:0]  in_y = '0;
    logic [0:0]  in_ch = '0;
    logic        in_ready, mem_we, busy, done, overflow, stray;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    // default-geometry instances share stimulus
    logic        start2 = 1'b0;
    logic [31:0] data2 = '0;
    logic        valid2 = 1'b0;
    logic [5:0]  x2 = '0;
    logic [5:0]  y2 = '0;
    logic [4:0]  ch2 = '0;
    logic        gnt2 = 1'b1;
    logic        dd_ready, dd_we, dd_busy, dd_done, dd_ovf, dd_stray;
    logic [19:0] dd_addr;
    logic [31:0] dd_wdata;
    logic        dw_ready, dw_we, dw_busy, dw_done, dw_ovf, dw_stray;
    logic [19:0] dw_addr;
    logic [31:0] dw_wdata;

    always #5 clk = ~clk;

    output_writeback #(
        .ACCUMULATION_WIDTH(16),
        .EXT_MEM_HEIGHT    (EMH),
        .EXT_MEM_WIDTH     (32),
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .OUTPUT_NB_CHANNELS(C),
        .FIFO_DEPTH        (8),
        .BASE_ADDR         (BASE)
    ) dut (
        .clk(clk), .arst_n_in(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .busy(busy), .done(done),
        .overflow(overflow), .stray(stray)
    );

    output_writeback dut_d (
        .clk(clk), .arst_n_in(rst_n), .start(start2), .in_data(data2),
        .in_valid(valid2), .in_x(x2), .in_y(y2), .in_ch(ch2),
        .in_ready(dd_ready), .mem_we(dd_we), .mem_addr(dd_addr),
        .mem_wdata(dd_wdata), .mem_gnt(gnt2), .busy(dd_busy), .done(dd_done),
        .overflow(dd_ovf), .stray(dd_stray)
    );

    output_writeback #(
        .BASE_ADDR(32'd1048572)
    ) dut_w (
        .clk(clk), .arst_n_in(rst_n), .start(start2), .in_data(data2),
        .in_valid(valid2), .in_x(x2), .in_y(y2), .in_ch(ch2),
        .in_ready(dw_ready), .mem_we(dw_we), .mem_addr(dw_addr),
        .mem_wdata(dw_wdata), .mem_gnt(gnt2), .busy(dw_busy), .done(dw_done),
        .overflow(dw_ovf), .stray(dw_stray)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Raster-order beat k of the small instance; optionally queue its expected write.
    task automatic drive_beat(input int k, input bit expect_push);
        int x, y, ch;
        ch = k % C;
        x  = (k / C) % W;
        y  = k / (C * W);
        in_x     = 2'(x);
        in_y     = 2'(y);
        in_ch    = 1'(ch);
        in_data  = 16'($urandom());
        in_valid = 1'b1;
        if (expect_push) begin
            exp_q.push_back('{addr: 10'((BASE + (y * W + x) * C + ch) % EMH),
                              data: {16'h0, in_data}});
        end
    endtask

    // Called right after driving mem_gnt for the coming edge.
    task automatic retire_check(inout int writes);
        wr_t e;
        if (mem_we && mem_gnt) begin
            writes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h expected no write", mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_layer(input int pct);
        int sent = 0, writes = 0, done_cnt = 0, cyc = 0, post = 0;
        bit hold = 0;
        logic [9:0]  h_addr = '0;
        logic [31:0] h_data = '0;
        pulse_start();
        while (cyc < 2000 && post < 4) begin
            @(negedge clk);
            cyc++;
            if (hold) chk("hold_stable", {31'h0, mem_we, 22'(mem_addr), mem_wdata},
                          {31'h0, 1'b1, 22'(h_addr), h_data});
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
            mem_gnt = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            if (sent < int'(TOT) && in_ready && (pct >= 100 || $urandom_range(3) != 0)) begin
                drive_beat(sent, 1'b1);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            retire_check(writes);
            hold   = mem_we && !mem_gnt;
            h_addr = mem_addr;
            h_data = mem_wdata;
        end
        in_valid = 1'b0;
        chk("layer_timeout", 64'(cyc >= 2000), 64'd0);
        chk("layer_writes", 64'(writes), 64'(TOT));
        chk("layer_queue_left", 64'(exp_q.size()), 64'd0);
        chk("layer_done_pulses", 64'(done_cnt), 64'd1);
        chk("layer_flags", {61'h0, overflow, stray, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   writes;
        bit   seen;
        vecs[0] = '{x: 6'd1,  y: 6'd0,  ch: 5'd0,  data: 32'hdeadbeef,
                    exp_d: 20'd32,     exp_w: 20'd28};
        vecs[1] = '{x: 6'd0,  y: 6'd1,  ch: 5'd5,  data: 32'h12345678,
                    exp_d: 20'd2053,   exp_w: 20'd2049};
        vecs[2] = '{x: 6'd63, y: 6'd63, ch: 5'd31, data: 32'h0000a5a5,
                    exp_d: 20'd131071, exp_w: 20'd131067};
        vecs[3] = '{x: 6'd0,  y: 6'd0,  ch: 5'd0,  data: 32'hffffffff,
                    exp_d: 20'd0,      exp_w: 20'd1048572};

        // Reset values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_outputs", {56'h0, mem_we, busy, done, overflow, stray, in_ready},
            64'h01);
        chk("rst_addr_data", {22'h0, mem_addr, mem_wdata}, 64'd0);

        // Address formation and wrap on default geometry
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x2 = vecs[i].x; y2 = vecs[i].y; ch2 = vecs[i].ch;
            data2 = vecs[i].data; valid2 = 1'b1;
            @(negedge clk) valid2 = 1'b0;
            chk("vec_latency_we", 64'(dd_we), 64'd0);
            @(negedge clk);
            chk("vec_we", {62'h0, dd_we, dw_we}, 64'd3);
            chk("vec_addr_d", 64'(dd_addr), 64'(vecs[i].exp_d));
            chk("vec_addr_w", 64'(dw_addr), 64'(vecs[i].exp_w));
            chk("vec_data", 64'(dd_wdata), 64'(vecs[i].data));
        end
        chk("vec_flags", {58'h0, dd_ovf, dd_stray, dw_ovf, dw_stray, dd_busy, dd_done},
            64'h2);

        // Stray beat while idle, cleared by start
        @(negedge clk) in_valid = 1'b1;
        @(negedge clk) in_valid = 1'b0;
        chk("stray_set", {62'h0, stray, mem_we}, 64'h2);
        @(negedge clk);
        chk("stray_no_write", 64'(mem_we), 64'd0);
        pulse_start();
        chk("stray_cleared", {62'h0, stray, busy}, 64'h1);

        // Overflow: grant held low, nine beats into eight entries
        mem_gnt = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 8) chk("ovf_before_9th", {62'h0, overflow, in_ready}, 64'd0);
            drive_beat(k, k < 8);
        end
        @(negedge clk) in_valid = 1'b0;
        chk("ovf_set", {62'h0, overflow, in_ready}, 64'h2);
        chk("ovf_head_held", {53'h0, mem_we, mem_addr}, {53'h0, 1'b1, 10'(BASE)});
        writes = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            mem_gnt = 1'b1;
            retire_check(writes);
        end
        chk("ovf_writes", 64'(writes), 64'd8);
        chk("ovf_queue_left", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with five entries queued
        mem_gnt = 1'b0;
        for (int k = 9; k < 14; k++) begin
            @(negedge clk);
            drive_beat(k, 1'b1);
        end
        @(negedge clk) in_valid = 1'b0;
        chk("pre_rst_busy_we", {62'h0, busy, mem_we}, 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_immediate", {61'h0, mem_we, busy, in_ready}, 64'h1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        mem_gnt = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | mem_we | busy;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);

        // Full layers against the reference queue
        run_layer(100);
        run_layer(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
